mesh_port_arbiter: RTL and testbench

- Four-requester arbiter that shares one mesh injection port between four upstream sources, for example the drain sides of several mesh_quad_fifo instances or match-engine lanes.
- Each requester presents a valid/ready flit carrying dst_x, dst_y and payload.
- The block picks one requester per cycle using burst-limited round-robin and drives a registered output stage toward the mesh.
- It also reports which source owns each output flit.

---
 rtl/mesh_port_arbiter_if.sv | 42 ++++
 rtl/mesh_port_arbiter.sv | 128 ++++++++++++
 tb/tb_mesh_port_arbiter.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mesh_port_arbiter_if.sv
// rtl/mesh_port_arbiter_if.sv - four-requester flit bus plus registered mesh injection output.
interface mesh_port_arbiter_if #(
  parameter int W      = 8,
  parameter int X_SIZE = 4,
  parameter int Y_SIZE = 4
);
  localparam int XW = $clog2(X_SIZE);
  localparam int YW = $clog2(Y_SIZE);

  logic          i_valid_0, i_valid_1, i_valid_2, i_valid_3;
  logic [XW-1:0] i_dst_x_0, i_dst_x_1, i_dst_x_2, i_dst_x_3;
  logic [YW-1:0] i_dst_y_0, i_dst_y_1, i_dst_y_2, i_dst_y_3;
  logic [W-1:0]  i_payload_0, i_payload_1, i_payload_2, i_payload_3;
  logic          i_ready_0, i_ready_1, i_ready_2, i_ready_3;

  logic          o_valid;
  logic [XW-1:0] o_dst_x;
  logic [YW-1:0] o_dst_y;
  logic [W-1:0]  o_payload;
  logic [1:0]    o_src;
  logic          o_ready;

  modport slave (
    input  i_valid_0, i_valid_1, i_valid_2, i_valid_3,
    input  i_dst_x_0, i_dst_x_1, i_dst_x_2, i_dst_x_3,
    input  i_dst_y_0, i_dst_y_1, i_dst_y_2, i_dst_y_3,
    input  i_payload_0, i_payload_1, i_payload_2, i_payload_3,
    output i_ready_0, i_ready_1, i_ready_2, i_ready_3,
    output o_valid, o_dst_x, o_dst_y, o_payload, o_src,
    input  o_ready
  );

  modport master (
    output i_valid_0, i_valid_1, i_valid_2, i_valid_3,
    output i_dst_x_0, i_dst_x_1, i_dst_x_2, i_dst_x_3,
    output i_dst_y_0, i_dst_y_1, i_dst_y_2, i_dst_y_3,
    output i_payload_0, i_payload_1, i_payload_2, i_payload_3,
    input  i_ready_0, i_ready_1, i_ready_2, i_ready_3,
    input  o_valid, o_dst_x, o_dst_y, o_payload, o_src,
    output o_ready
  );
endinterface

// File: rtl/mesh_port_arbiter.sv
// rtl/mesh_port_arbiter.sv - burst-limited round-robin arbiter feeding one registered mesh injection port.
module mesh_port_arbiter #(
  parameter int W         = 8,
  parameter int X_SIZE    = 4,
  parameter int Y_SIZE    = 4,
  parameter int MAX_BURST = 4
) (
  input logic                clk,
  input logic                rst_n,
  mesh_port_arbiter_if.slave bus
);
  localparam int XW = $clog2(X_SIZE);
  localparam int YW = $clog2(Y_SIZE);
  localparam int BW = $clog2(MAX_BURST + 1);

  logic [3:0]    valid;
  logic [XW-1:0] dst_x   [4];
  logic [YW-1:0] dst_y   [4];
  logic [W-1:0]  payload [4];

  assign valid      = {bus.i_valid_3, bus.i_valid_2, bus.i_valid_1, bus.i_valid_0};
  assign dst_x[0]   = bus.i_dst_x_0;
  assign dst_x[1]   = bus.i_dst_x_1;
  assign dst_x[2]   = bus.i_dst_x_2;
  assign dst_x[3]   = bus.i_dst_x_3;
  assign dst_y[0]   = bus.i_dst_y_0;
  assign dst_y[1]   = bus.i_dst_y_1;
  assign dst_y[2]   = bus.i_dst_y_2;
  assign dst_y[3]   = bus.i_dst_y_3;
  assign payload[0] = bus.i_payload_0;
  assign payload[1] = bus.i_payload_1;
  assign payload[2] = bus.i_payload_2;
  assign payload[3] = bus.i_payload_3;

  logic [1:0]    last_owner_q, last_owner_d;
  logic [BW-1:0] burst_cnt_q, burst_cnt_d;
  logic          o_valid_q, o_valid_d;
  logic [XW-1:0] o_dst_x_q, o_dst_x_d;
  logic [YW-1:0] o_dst_y_q, o_dst_y_d;
  logic [W-1:0]  o_payload_q, o_payload_d;
  logic [1:0]    o_src_q, o_src_d;

  logic          continue_burst;
  logic          grant_any;
  logic [1:0]    grant_idx;
  logic [1:0]    scan_idx;
  logic          load_en;
  logic          accept;

  assign continue_burst = valid[last_owner_q] && (burst_cnt_q < BW'(MAX_BURST));
  assign load_en        = ~o_valid_q | bus.o_ready;
  assign accept         = load_en & grant_any;

  // The scan's fourth step lands back on last_owner, so a lone requester is re-granted with a fresh burst.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    if (continue_burst) begin
      grant_any = 1'b1;
      grant_idx = last_owner_q;
    end else begin
      for (int k = 1; k <= 4; k++) begin
        scan_idx = last_owner_q + 2'(k);
        if (!grant_any && valid[scan_idx]) begin
          grant_any = 1'b1;
          grant_idx = scan_idx;
        end
      end
    end
  end

  assign bus.i_ready_0 = accept & (grant_idx == 2'd0);
  assign bus.i_ready_1 = accept & (grant_idx == 2'd1);
  assign bus.i_ready_2 = accept & (grant_idx == 2'd2);
  assign bus.i_ready_3 = accept & (grant_idx == 2'd3);

  always_comb begin
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    o_valid_d    = o_valid_q;
    o_dst_x_d    = o_dst_x_q;
    o_dst_y_d    = o_dst_y_q;
    o_payload_d  = o_payload_q;
    o_src_d      = o_src_q;
    if (accept) begin
      o_valid_d   = 1'b1;
      o_dst_x_d   = dst_x[grant_idx];
      o_dst_y_d   = dst_y[grant_idx];
      o_payload_d = payload[grant_idx];
      o_src_d     = grant_idx;
      if (continue_burst) begin
        burst_cnt_d = burst_cnt_q + 1'b1;
      end else begin
        burst_cnt_d  = BW'(1);
        last_owner_d = grant_idx;
      end
    end else if (load_en) begin
      o_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_owner_q <= 2'd3;
      burst_cnt_q  <= BW'(MAX_BURST);
      o_valid_q    <= 1'b0;
      o_dst_x_q    <= '0;
      o_dst_y_q    <= '0;
      o_payload_q  <= '0;
      o_src_q      <= '0;
    end else begin
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      o_valid_q    <= o_valid_d;
      o_dst_x_q    <= o_dst_x_d;
      o_dst_y_q    <= o_dst_y_d;
      o_payload_q  <= o_payload_d;
      o_src_q      <= o_src_d;
    end
  end

  assign bus.o_valid   = o_valid_q;
  assign bus.o_dst_x   = o_dst_x_q;
  assign bus.o_dst_y   = o_dst_y_q;
  assign bus.o_payload = o_payload_q;
  assign bus.o_src     = o_src_q;
endmodule

// File: tb/tb_mesh_port_arbiter.sv
// tb/tb_mesh_port_arbiter.sv - drives pure round-robin and burst-4 arbiters with identical stimulus against a flit-level model.
module tb_mesh_port_arbiter;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] v = 4'h0;
  logic [7:0] pl [4];
  logic [1:0] dx [4];
  logic [1:0] dy [4];
  logic       ordy = 1'b1;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  mesh_port_arbiter_if #(.W(8), .X_SIZE(4), .Y_SIZE(4)) b1 ();
  mesh_port_arbiter_if #(.W(8), .X_SIZE(4), .Y_SIZE(4)) b4 ();

  mesh_port_arbiter #(.W(8), .X_SIZE(4), .Y_SIZE(4), .MAX_BURST(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mesh_port_arbiter #(.W(8), .X_SIZE(4), .Y_SIZE(4), .MAX_BURST(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

  assign b1.i_valid_0 = v[0];   assign b1.i_valid_1 = v[1];   assign b1.i_valid_2 = v[2];   assign b1.i_valid_3 = v[3];
  assign b1.i_dst_x_0 = dx[0];  assign b1.i_dst_x_1 = dx[1];  assign b1.i_dst_x_2 = dx[2];  assign b1.i_dst_x_3 = dx[3];
  assign b1.i_dst_y_0 = dy[0];  assign b1.i_dst_y_1 = dy[1];  assign b1.i_dst_y_2 = dy[2];  assign b1.i_dst_y_3 = dy[3];
  assign b1.i_payload_0 = pl[0]; assign b1.i_payload_1 = pl[1]; assign b1.i_payload_2 = pl[2]; assign b1.i_payload_3 = pl[3];
  assign b1.o_ready = ordy;
  assign b4.i_valid_0 = v[0];   assign b4.i_valid_1 = v[1];   assign b4.i_valid_2 = v[2];   assign b4.i_valid_3 = v[3];
  assign b4.i_dst_x_0 = dx[0];  assign b4.i_dst_x_1 = dx[1];  assign b4.i_dst_x_2 = dx[2];  assign b4.i_dst_x_3 = dx[3];
  assign b4.i_dst_y_0 = dy[0];  assign b4.i_dst_y_1 = dy[1];  assign b4.i_dst_y_2 = dy[2];  assign b4.i_dst_y_3 = dy[3];
  assign b4.i_payload_0 = pl[0]; assign b4.i_payload_1 = pl[1]; assign b4.i_payload_2 = pl[2]; assign b4.i_payload_3 = pl[3];
  assign b4.o_ready = ordy;

  logic       d_ov  [2];
  logic [1:0] d_src [2];
  logic [7:0] d_pl  [2];
  logic [1:0] d_dx  [2];
  logic [1:0] d_dy  [2];
  logic [3:0] d_rdy [2];
  assign d_ov[0]  = b1.o_valid;   assign d_ov[1]  = b4.o_valid;
  assign d_src[0] = b1.o_src;     assign d_src[1] = b4.o_src;
  assign d_pl[0]  = b1.o_payload; assign d_pl[1]  = b4.o_payload;
  assign d_dx[0]  = b1.o_dst_x;   assign d_dx[1]  = b4.o_dst_x;
  assign d_dy[0]  = b1.o_dst_y;   assign d_dy[1]  = b4.o_dst_y;
  assign d_rdy[0] = {b1.i_ready_3, b1.i_ready_2, b1.i_ready_1, b1.i_ready_0};
  assign d_rdy[1] = {b4.i_ready_3, b4.i_ready_2, b4.i_ready_1, b4.i_ready_0};

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Flit-level model: who owns the port, how many flits in a row they have had, and the flit on the wire.
  int limit [2] = '{1, 4};
  int owner [2];
  int run   [2];
  int m_ov  [2];
  int m_src [2];
  int m_pl  [2];
  int m_dx  [2];
  int m_dy  [2];

  function automatic int pick(input int lo, input int cnt, input int lim, input logic [3:0] vv);
    if (vv[lo] && cnt < lim) return lo;
    for (int k = 1; k <= 4; k++)
      if (vv[(lo + k) % 4]) return (lo + k) % 4;
    return -1;
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      owner[n] = 3; run[n] = limit[n];
      m_ov[n] = 0; m_src[n] = 0; m_pl[n] = 0; m_dx[n] = 0; m_dy[n] = 0;
    end
  endtask

  initial model_reset();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int n = 0; n < 2; n++) begin
        int g;
        g = pick(owner[n], run[n], limit[n], v);
        if (m_ov[n] == 0 || ordy) begin
          if (g >= 0) begin
            m_ov[n] = 1; m_src[n] = g; m_pl[n] = pl[g]; m_dx[n] = dx[g]; m_dy[n] = dy[g];
            if (g == owner[n] && run[n] < limit[n]) run[n] = run[n] + 1;
            else begin run[n] = 1; owner[n] = g; end
          end else begin
            m_ov[n] = 0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      for (int n = 0; n < 2; n++) begin
        int g;
        int exp_rdy;
        g = pick(owner[n], run[n], limit[n], v);
        exp_rdy = ((m_ov[n] == 0 || ordy) && g >= 0) ? (1 << g) : 0;
        chk($sformatf("u%0d_i_ready", n), int'(d_rdy[n]), exp_rdy);
        chk($sformatf("u%0d_o_valid", n), int'(d_ov[n]), m_ov[n]);
        chk($sformatf("u%0d_o_src", n), int'(d_src[n]), m_src[n]);
        chk($sformatf("u%0d_o_payload", n), int'(d_pl[n]), m_pl[n]);
        chk($sformatf("u%0d_o_dst_x", n), int'(d_dx[n]), m_dx[n]);
        chk($sformatf("u%0d_o_dst_y", n), int'(d_dy[n]), m_dy[n]);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v = 4'h0;
    ordy = 1'b1;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
  endtask

  task automatic chk_flit(input string name, input int n, input int src);
    chk($sformatf("%s_u%0d_valid", name, n), int'(d_ov[n]), 1);
    chk($sformatf("%s_u%0d_src", name, n), int'(d_src[n]), src);
  endtask

  initial begin
    int s1 [10];
    int s4 [10];
    for (int k = 0; k < 4; k++) begin
      pl[k] = 8'hA0 + 8'(k); dx[k] = 2'(k); dy[k] = 2'(3 - k);
    end

    // Reset values, then all four requesters continuously.
    do_reset();
    for (int n = 0; n < 2; n++) begin
      chk("reset_o_valid", int'(d_ov[n]), 0);
      chk("reset_o_src", int'(d_src[n]), 0);
      chk("reset_o_payload", int'(d_pl[n]), 0);
      chk("reset_o_dst", int'({d_dx[n], d_dy[n]}), 0);
    end
    v = 4'hF;
    #1;
    chk("rr_first_ready_u1", int'(d_rdy[0]), 1);
    chk("rr_first_ready_u4", int'(d_rdy[1]), 1);
    chk("rr_no_valid_before_edge", int'(d_ov[0]), 0);
    s1 = '{0, 1, 2, 3, 0, 1, 0, 0, 0, 0};
    s4 = '{0, 0, 0, 0, 1, 1, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_flit("rr", 0, s1[i]);
      chk_flit("rr", 1, s4[i]);
    end
    chk("rr_payload_u1", int'(d_pl[0]), 8'hA1);

    // Two competitors: requesters 0 and 2.
    do_reset();
    v = 4'b0101;
    s1 = '{0, 2, 0, 2, 0, 2, 0, 2, 0, 0};
    s4 = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0};
    for (int i = 0; i < 9; i++) begin
      tick();
      chk_flit("burst", 0, s1[i]);
      chk_flit("burst", 1, s4[i]);
    end

    // Lone requester 1 for ten cycles, no bubbles.
    do_reset();
    v = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("lone_ready_u1", int'(d_rdy[0]), 2);
      chk("lone_ready_u4", int'(d_rdy[1]), 2);
      @(posedge clk); #1;
      chk_flit("lone", 0, 1);
      chk_flit("lone", 1, 1);
      #1;
    end
    v = 4'h0;

    // Output stall holding 0x5A.
    do_reset();
    v = 4'b0001; pl[0] = 8'h5A;
    tick();
    chk("stall_load_u4", int'(d_pl[1]), 8'h5A);
    ordy = 1'b0; v = 4'hF; pl[0] = 8'h50;
    #1;
    chk("stall_ready_u1", int'(d_rdy[0]), 0);
    chk("stall_ready_u4", int'(d_rdy[1]), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_payload_u1", int'(d_pl[0]), 8'h5A);
      chk("stall_payload_u4", int'(d_pl[1]), 8'h5A);
      chk("stall_valid_u4", int'(d_ov[1]), 1);
      chk("stall_ready_held", int'(d_rdy[0] | d_rdy[1]), 0);
    end
    ordy = 1'b1;
    #1;
    chk("release_ready_u1", int'(d_rdy[0]), 2);
    chk("release_ready_u4", int'(d_rdy[1]), 1);
    tick();
    chk_flit("release", 0, 1);
    chk_flit("release", 1, 0);
    chk("release_payload_u4", int'(d_pl[1]), 8'h50);
    pl[0] = 8'hA0;

    // Requester 0 drops out after two flits of its burst.
    do_reset();
    v = 4'b1011;
    s1 = '{0, 1, 3, 1, 3, 1, 3, 1, 0, 0};
    s4 = '{0, 0, 1, 1, 1, 1, 3, 3, 0, 0};
    for (int i = 0; i < 8; i++) begin
      tick();
      chk_flit("drop", 0, s1[i]);
      chk_flit("drop", 1, s4[i]);
      if (i == 1) v = 4'b1010;
    end

    // Asynchronous reset while a flit is stalled on the port.
    do_reset();
    v = 4'b0001; ordy = 1'b0;
    tick();
    tick();
    chk("areset_pre_valid", int'(d_ov[1]), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("areset_drop_u1", int'(d_ov[0]), 0);
    chk("areset_drop_u4", int'(d_ov[1]), 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    v = 4'hF; ordy = 1'b1;
    tick();
    chk_flit("areset_restart", 0, 0);
    chk_flit("areset_restart", 1, 0);
    tick();
    chk_flit("areset_next", 0, 1);
    chk_flit("areset_next", 1, 0);

    v = 4'h0;
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
